dcache_wt: RTL and testbench

- Blocking, direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the 3-stage RISC-V datapath. It consumes dcache_addr/dcache_re/dcache_we/dcache_din and returns dcache_dout plus the pipeline stall.
- Refills and writes go to main memory over a single 128-bit valid/ready request channel with an in-order response channel.

---
 rtl/dcache_wt_pkg.sv | 19 +
 rtl/dcache_wt_array.sv | 46 ++++
 rtl/dcache_wt.sv | 182 ++++++++++++++++++
 tb/tb_dcache_wt.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wt_pkg.sv
// Shared constants for the write-through data cache: FSM encodings, line geometry and memory address width.
package dcache_wt_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;
    localparam int MEM_ADDR_W = 28;
    localparam int LINE_W     = LINE_BYTES * 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MISS_REQ  = 3'd1;
    localparam logic [2:0] ST_MISS_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ    = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    function automatic int tag_width(input int idx_w);
        return 32 - OFFSET_W - idx_w;
    endfunction

endpackage

// File: rtl/dcache_wt_array.sv
// Single-port tag+data storage for the cache: synchronous read, byte-masked write.
// Read data appears one cycle after rd_en; a write takes priority over a read in the same cycle.
module dcache_array
    import dcache_wt_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = tag_width(IDX_W)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic                  wr_tag_en,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic [LINE_BYTES-1:0] wr_be,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_data
);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  rd_tag_q;
    logic [LINE_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_tag_en) begin
                tag_mem[idx] <= wr_tag;
            end
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wr_be[b]) begin
                    data_mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end else if (rd_en) begin
            rd_tag_q  <= tag_mem[idx];
            rd_data_q <= data_mem[idx];
        end
    end

    assign rd_tag  = rd_tag_q;
    assign rd_data = rd_data_q;

endmodule

// File: rtl/dcache_wt.sv
// Blocking direct-mapped write-through, no-write-allocate data cache in front of a 128-bit memory channel.
// Load hit: data in the cycle after acceptance, no stall; misses and all stores stall until memory completes.
module dcache_wt
    import dcache_wt_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           cpu_addr,
    input  logic                  cpu_re,
    input  logic [3:0]            cpu_we,
    input  logic [31:0]           cpu_din,
    output logic [31:0]           cpu_dout,
    output logic                  stall,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [MEM_ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0]     mem_req_data,
    output logic [LINE_BYTES-1:0] mem_req_mask,
    input  logic                  mem_resp_valid,
    input  logic [LINE_W-1:0]     mem_resp_data
);

    localparam int TAG_W = tag_width(IDX_W);

    logic [2:0]       state_q,   state_d;
    logic             pending_q, pending_d;
    logic [31:2]      addr_q,    addr_d;
    logic [3:0]       we_q,      we_d;
    logic [31:0]      din_q,     din_d;
    logic             store_q,   store_d;
    logic [31:0]      dout_q,    dout_d;
    logic [LINES-1:0] valid_q,   valid_d;

    logic [IDX_W-1:0]      idx_cur;
    logic [TAG_W-1:0]      tag_cur;
    logic [1:0]            off_cur;
    logic [LINE_BYTES-1:0] store_mask;
    logic                  hit, compare, load_hit, cpu_req, accept;
    logic [31:0]           hit_word, resp_word;

    logic                  arr_rd_en, arr_wr_en, arr_tag_en;
    logic [IDX_W-1:0]      arr_idx;
    logic [LINE_W-1:0]     arr_wr_data;
    logic [LINE_BYTES-1:0] arr_wr_be;
    logic [TAG_W-1:0]      arr_rd_tag;
    logic [LINE_W-1:0]     arr_rd_data;

    // Byte offset within the word plays no role in a word-granular cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign idx_cur    = addr_q[4 +: IDX_W];
    assign tag_cur    = addr_q[31 -: TAG_W];
    assign off_cur    = addr_q[3:2];
    assign store_mask = LINE_BYTES'(we_q) << {off_cur, 2'b00};
    assign hit_word   = arr_rd_data[{off_cur, 5'b0} +: 32];
    assign resp_word  = mem_resp_data[{off_cur, 5'b0} +: 32];

    assign hit      = valid_q[idx_cur] && (arr_rd_tag == tag_cur);
    assign compare  = (state_q == ST_IDLE) && pending_q;
    assign load_hit = compare && !store_q && hit;
    assign stall    = (state_q == ST_MISS_REQ) || (state_q == ST_MISS_WAIT) ||
                      (state_q == ST_WR_REQ) || (compare && !load_hit);
    assign cpu_req  = cpu_re || (|cpu_we);
    assign accept   = cpu_req && !stall;
    assign cpu_dout = load_hit ? hit_word : dout_q;

    assign mem_req_valid = (state_q == ST_MISS_REQ) || (state_q == ST_WR_REQ);
    assign mem_req_rw    = (state_q == ST_WR_REQ);
    assign mem_req_addr  = addr_q[31:4];
    assign mem_req_data  = {4{din_q}};
    assign mem_req_mask  = mem_req_rw ? store_mask : '0;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        addr_d      = addr_q;
        we_d        = we_q;
        din_d       = din_q;
        store_d     = store_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        arr_wr_en   = 1'b0;
        arr_tag_en  = 1'b0;
        arr_wr_be   = '0;
        arr_wr_data = {4{din_q}};

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    if (store_q) begin
                        state_d = ST_WR_REQ;
                        if (hit) begin
                            arr_wr_en = 1'b1;
                            arr_wr_be = store_mask;
                        end
                    end else if (hit) begin
                        dout_d = hit_word;
                    end else begin
                        state_d = ST_MISS_REQ;
                    end
                end
            end
            ST_MISS_REQ: begin
                if (mem_req_ready) state_d = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (mem_resp_valid) begin
                    arr_wr_en         = 1'b1;
                    arr_tag_en        = 1'b1;
                    arr_wr_be         = '1;
                    arr_wr_data       = mem_resp_data;
                    valid_d[idx_cur]  = 1'b1;
                    dout_d            = resp_word;
                    state_d           = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                if (mem_req_ready) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            addr_d    = cpu_addr[31:2];
            we_d      = cpu_we;
            din_d     = cpu_din;
            store_d   = |cpu_we;
            pending_d = 1'b1;
        end
    end

    // A write never coincides with an accept, so the single port is steered by the write.
    assign arr_rd_en = accept;
    assign arr_idx   = arr_wr_en ? idx_cur : cpu_addr[4 +: IDX_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= '0;
            din_q     <= '0;
            store_q   <= 1'b0;
            dout_q    <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            din_q     <= din_d;
            store_q   <= store_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
        end
    end

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .idx       (arr_idx),
        .rd_en     (arr_rd_en),
        .wr_en     (arr_wr_en),
        .wr_tag_en (arr_tag_en),
        .wr_tag    (tag_cur),
        .wr_data   (arr_wr_data),
        .wr_be     (arr_wr_be),
        .rd_tag    (arr_rd_tag),
        .rd_data   (arr_rd_data)
    );

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt with a transaction-level cache/memory model.
module tb_dcache_wt;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cpu_addr;
    logic         cpu_re;
    logic [3:0]   cpu_we;
    logic [31:0]  cpu_din;
    logic [31:0]  cpu_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    always #5 clk = ~clk;

    dcache_wt #(.LINES(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: backing memory by word address, plus cache lines by index.
    logic [31:0] mem [logic [29:0]];
    bit          mv   [64];
    logic [21:0] mt   [64];
    logic [31:0] mdat [64][4];
    logic [31:0] mdout;
    int          exp_reqs = 0;

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return ({2'b0, wa} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Request-channel monitor: handshake count, last request, hold-while-stalled.
    int           reqs_seen = 0;
    logic         last_rw;
    logic [27:0]  last_addr;
    logic [15:0]  last_mask;
    logic [127:0] last_data;
    bit           prev_stuck = 0;
    logic [173:0] prev_fields;

    always @(negedge clk) begin
        #1;
        if (reset) begin
            prev_stuck = 0;
        end else begin
            if (prev_stuck)
                chk("req_hold", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_mask, mem_req_data},
                    prev_fields);
            prev_fields = {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_mask, mem_req_data};
            prev_stuck  = mem_req_valid && !mem_req_ready;
            if (mem_req_valid && mem_req_ready) begin
                reqs_seen++;
                last_rw   = mem_req_rw;
                last_addr = mem_req_addr;
                last_mask = mem_req_mask;
                last_data = mem_req_data;
            end
        end
    end

    task automatic chk_req(input bit rw, input logic [27:0] a, input logic [15:0] m,
                           input logic [127:0] d);
        chk("req_valid", mem_req_valid, 1'b1);
        chk("req_stall", stall, 1'b1);
        chk("req_rw", mem_req_rw, rw);
        chk("req_addr", mem_req_addr, a);
        chk("req_mask", mem_req_mask, m);
        if (rw) chk("req_data", mem_req_data, d);
    endtask

    // Called at a negedge with the cache ready; returns at a negedge with stall expected low.
    task automatic do_access(input bit is_store, input logic [31:0] a, input logic [3:0] we,
                             input logic [31:0] din, input int rdy_dly, input int rsp_dly);
        logic [5:0]   idx;
        logic [1:0]   off;
        bit           hit;
        logic [15:0]  mask;
        logic [127:0] line;
        idx  = a[9:4];
        off  = a[3:2];
        hit  = mv[idx] && (mt[idx] == a[31:10]);
        mask = '0;
        for (int b = 0; b < 4; b++) if (is_store && we[b]) mask[4*off + b] = 1'b1;

        cpu_addr = a;
        cpu_re   = is_store ? 1'($urandom_range(0, 1)) : 1'b1;
        cpu_we   = is_store ? we : 4'b0;
        cpu_din  = din;
        @(negedge clk);
        cpu_re   = 1'b0;
        cpu_we   = 4'b0;
        cpu_addr = $urandom;
        cpu_din  = $urandom;

        if (!is_store && hit) begin
            mdout = mdat[idx][off];
            chk("hit_stall", stall, 1'b0);
            chk("hit_dout", cpu_dout, mdout);
            return;
        end
        chk("cmp_stall", stall, 1'b1);
        chk("cmp_novalid", mem_req_valid, 1'b0);
        exp_reqs++;
        @(negedge clk);
        for (int i = 0; i < rdy_dly; i++) begin
            chk_req(is_store, a[31:4], mask, {4{din}});
            @(negedge clk);
        end
        chk_req(is_store, a[31:4], mask, {4{din}});
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;

        if (is_store) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    logic [31:0] w;
                    w = mem_rd(a[31:2]);
                    w[8*b +: 8] = din[8*b +: 8];
                    mem[a[31:2]] = w;
                    if (hit) mdat[idx][off][8*b +: 8] = din[8*b +: 8];
                end
            end
        end else begin
            for (int i = 0; i < rsp_dly; i++) begin
                chk("wait_stall", stall, 1'b1);
                chk("wait_novalid", mem_req_valid, 1'b0);
                @(negedge clk);
            end
            for (int w = 0; w < 4; w++) line[32*w +: 32] = mem_rd({a[31:4], 2'(w)});
            mem_resp_valid = 1'b1;
            mem_resp_data  = line;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_data  = {4{$urandom}};
            mv[idx] = 1'b1;
            mt[idx] = a[31:10];
            for (int w = 0; w < 4; w++) mdat[idx][w] = line[32*w +: 32];
            mdout = mdat[idx][off];
        end
        chk("resp_stall", stall, 1'b0);
        chk("resp_novalid", mem_req_valid, 1'b0);
        chk("resp_dout", cpu_dout, mdout);
    endtask

    // Idle cycles with stray responses that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("idle_stall", stall, 1'b0);
            chk("idle_novalid", mem_req_valid, 1'b0);
            chk("idle_dout", cpu_dout, mdout);
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        cpu_addr = a;
        cpu_re   = 1'b1;
        @(negedge clk);
        cpu_re = 1'b0;
        chk("rmm_cmp_stall", stall, 1'b1);
        @(negedge clk);
        chk("rmm_req_valid", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        exp_reqs++;
        @(negedge clk);
        chk("rmm_wait_stall", stall, 1'b1);
        reset = 1'b1;
        #1;
        chk("rmm_rst_stall", stall, 1'b0);
        chk("rmm_rst_valid", mem_req_valid, 1'b0);
        chk("rmm_rst_dout", cpu_dout, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        mdout = '0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {4{32'hDEAD_BEEF}};
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("rmm_late_stall", stall, 1'b0);
        chk("rmm_late_valid", mem_req_valid, 1'b0);
        chk("rmm_late_dout", cpu_dout, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        reset          = 1'b1;
        cpu_addr       = '0;
        cpu_re         = 1'b0;
        cpu_we         = '0;
        cpu_din        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mdout          = '0;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_valid", mem_req_valid, 1'b0);
        chk("rst_dout", cpu_dout, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Cold load and hit on the same line.
        mem[30'h0400_0004] = 32'hAAAA_0001;
        mem[30'h0400_0005] = 32'hBBBB_0002;
        mem[30'h0400_0006] = 32'hCCCC_0003;
        mem[30'h0400_0007] = 32'hDDDD_0004;
        do_access(0, 32'h1000_0010, 4'b0, 32'h0, 0, 2);
        chk("cold_addr", last_addr, 28'h100_0001);
        chk("cold_rw", last_rw, 1'b0);
        chk("cold_dout", cpu_dout, 32'hAAAA_0001);
        do_access(0, 32'h1000_0014, 4'b0, 32'h0, 0, 0);
        chk("hit_b_dout", cpu_dout, 32'hBBBB_0002);

        // Store hit, then read back the merged word.
        do_access(1, 32'h1000_0018, 4'b0011, 32'h0000_BEEF, 2, 0);
        chk("st_mask", last_mask, 16'h0300);
        chk("st_data", last_data, {4{32'h0000_BEEF}});
        chk("st_rw", last_rw, 1'b1);
        do_access(0, 32'h1000_0018, 4'b0, 32'h0, 0, 0);
        chk("st_merge", cpu_dout, 32'hCCCC_BEEF);

        // Store miss does not allocate.
        base = reqs_seen;
        do_access(1, 32'h1000_1000, 4'b1111, 32'h1234_5678, 0, 0);
        do_access(0, 32'h1000_1000, 4'b0, 32'h0, 0, 1);
        chk("nwa_reqs", reqs_seen - base, 2);
        chk("nwa_rw", last_rw, 1'b0);
        chk("nwa_dout", cpu_dout, 32'h1234_5678);

        // Conflict eviction on index 0.
        base = reqs_seen;
        do_access(0, 32'h1000_0000, 4'b0, 32'h0, 0, 0);
        do_access(0, 32'h1000_0400, 4'b0, 32'h0, 0, 0);
        do_access(0, 32'h1000_0000, 4'b0, 32'h0, 0, 0);
        chk("conflict_reqs", reqs_seen - base, 3);

        // Backpressure then long response latency.
        base = reqs_seen;
        do_access(0, 32'h1000_0800, 4'b0, 32'h0, 5, 10);
        chk("bp_reqs", reqs_seen - base, 1);

        // Back-to-back hits across one line.
        for (int w = 0; w < 4; w++) do_access(0, 32'h1000_0800 + 32'(4 * w), 4'b0, 32'h0, 0, 0);

        // Reset during a miss; the line must miss again afterwards.
        reset_mid_miss(32'h1000_0030);
        base = reqs_seen;
        do_access(0, 32'h1000_0030, 4'b0, 32'h0, 0, 0);
        chk("rmm_remiss", reqs_seen - base, 1);
        idle(3);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = 32'h1000_0000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 7) << 4)
                + ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 3) == 0)
                do_access(1, a, 4'($urandom_range(1, 15)), $urandom,
                          $urandom_range(0, 3), 0);
            else
                do_access(0, a, 4'b0, 32'h0, $urandom_range(0, 3), $urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        chk("req_count", reqs_seen, exp_reqs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
